// File: rtl/stream_mux_pkg.sv
// Shared types for the round-robin stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational grant logic: static pick of sel, or first requester at/after ptr with wrap.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  mux_mode_e         mode,
    input  logic [CH_W-1:0]   sel,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    localparam int unsigned NUM_CH_U = NUM_CH;

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (mode == MODE_RR) begin
            for (int unsigned k = 0; k < NUM_CH_U; k++) begin
                idx = (32'(ptr) + k) % NUM_CH_U;
                if (!found && req[idx]) begin
                    found          = 1'b1;
                    grant[idx]     = 1'b1;
                    grant_idx      = CH_W'(idx);
                end
            end
        end else begin
            // Compare against each legal index so sel >= NUM_CH never indexes out of range.
            for (int unsigned i = 0; i < NUM_CH_U; i++) begin
                if (sel == CH_W'(i) && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with static or round-robin selection and a registered output.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  mux_mode_e               mode,
    input  logic [CH_W-1:0]         sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    localparam int unsigned NUM_CH_U = NUM_CH;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  sel_data;
    logic              can_load;
    logic              handshake;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic [CH_W-1:0]   ptr_q,       ptr_d;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (mode),
        .sel       (sel),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH_U; i++) begin
            if (grant_idx == CH_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign can_load  = !out_valid_q || out_ready;
    assign in_ready  = (rst_n && can_load) ? grant : '0;
    assign handshake = |(in_valid & in_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (handshake) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
            if (mode == MODE_RR)
                ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reference grant model plus output scoreboard.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    mux_mode_e   mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    mux_mode_e   mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [11:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [3:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    stream_mux_rr #(.NUM_CH(4), .WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.NUM_CH(3), .WIDTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] ch;
    } word_t;

    word_t sb[$];
    int    ch_log[$];
    int    m_ptr;
    logic  m_valid;
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_grant();
        logic [3:0] g;
        int c;
        g = '0;
        if (mode == MODE_STATIC) begin
            if (in_valid[sel]) g[sel] = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (g == 4'b0 && in_valid[c]) g[c] = 1'b1;
            end
        end
        return g;
    endfunction

    // One cycle: check at the falling edge, update model, advance to just past the rising edge.
    task automatic step();
        logic [3:0] er;
        word_t      w;
        int         gch;
        @(negedge clk);
        er = (!m_valid || out_ready) ? exp_grant() : 4'b0;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (out_valid) ch_log.push_back(int'(out_ch));
        if (m_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                w = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(w.d));
                chk("out_ch", 32'(out_ch), 32'(w.ch));
            end
        end
        gch = -1;
        for (int i = 0; i < 4; i++) if (er[i]) gch = i;
        if (gch >= 0) begin
            w.d  = in_data[gch*4 +: 4];
            w.ch = 2'(gch);
            sb.push_back(w);
            m_valid = 1'b1;
            if (mode == MODE_RR) m_ptr = (gch == 3) ? 0 : gch + 1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = MODE_RR; sel = 2'd0; in_valid = 4'b1111;
        in_data = {4'd3, 4'd2, 4'd1, 4'd0}; out_ready = 1'b0;
        mode3 = MODE_STATIC; sel3 = 2'd0; in_valid3 = 3'b000;
        in_data3 = {4'd6, 4'd5, 4'd4}; out_ready3 = 1'b1;
        m_ptr = 0; m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b1;

        // Reset mid-transfer while stalled
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(0));
        sb.delete(); m_valid = 1'b0; m_ptr = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("first_rr_grant", 32'(in_ready), 32'(4'b0001));

        // RR all valid, no bubbles
        ch_log.delete();
        repeat (6) step();
        in_valid = 4'b0000;
        step();
        chk("rr_log_len", 32'(ch_log.size()), 32'(6));
        for (int i = 0; i < 6 && i < ch_log.size(); i++)
            chk($sformatf("rr_seq%0d", i), 32'(ch_log[i]), 32'(i % 4));

        // RR with channels 1 and 3 only
        ch_log.delete();
        in_valid = 4'b1010;
        repeat (4) step();
        in_valid = 4'b0000;
        step();
        chk("alt_log_len", 32'(ch_log.size()), 32'(4));
        for (int i = 0; i < 4 && i < ch_log.size(); i++)
            chk($sformatf("alt_seq%0d", i), 32'(ch_log[i]), 32'((i % 2 == 0) ? 3 : 1));

        // Backpressure
        in_data = {4'd3, 4'd2, 4'd1, 4'b1000};
        in_valid = 4'b0001;
        out_ready = 1'b0;
        step();
        in_valid = 4'b0011;
        repeat (3) begin
            step();
            chk("stall_data", 32'(out_data), 32'(4'b1000));
            chk("stall_ch", 32'(out_ch), 32'(0));
        end
        out_ready = 1'b1;
        step();
        chk("resume_load_ch", 32'(out_ch), 32'(1));
        step();
        in_valid = 4'b0000;
        repeat (2) step();

        // Static select
        mode = MODE_STATIC; sel = 2'b10; in_valid = 4'b1111;
        in_data = {4'd3, 4'd2, 4'd1, 4'd0};
        #1;
        chk("static_in_ready", 32'(in_ready), 32'(4'b0100));
        step();
        chk("static_out_data", 32'(out_data), 32'(4'b0010));
        chk("static_out_ch", 32'(out_ch), 32'(2));
        sel = 2'b01;
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        chk("sb_empty", 32'(sb.size()), 32'(0));

        // Three-channel instance, out-of-range sel
        sel3 = 2'b11; in_valid3 = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("n3_in_ready", 32'(in_ready3), 32'(3'b000));
        chk("n3_out_valid", 32'(out_valid3), 32'(0));
        sel3 = 2'b01;
        #1;
        chk("n3_sel1_ready", 32'(in_ready3), 32'(3'b010));
        @(posedge clk);
        #1;
        chk("n3_out_valid1", 32'(out_valid3), 32'(1));
        chk("n3_out_data", 32'(out_data3), 32'(4'd5));
        chk("n3_out_ch", 32'(out_ch3), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
